// File: rtl/sreg_pkg.sv
// Shared types for the serial shift-register controller: opcodes, FSM states
// and the opcode decoder used at the command handshake.
package sreg_pkg;

    typedef enum logic [2:0] {
        CLEAR       = 3'd0,
        WRITE       = 3'd1,
        READ        = 3'd2,
        WRITE_READ  = 3'd3,
        LATCH       = 3'd4,
        WRITE_LATCH = 3'd5
    } sreg_cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCLK_LO,
        SCLK_HI,
        HOLD,
        CFG,
        RESP
    } sreg_state_t;

    typedef struct packed {
        logic is_write;   // shift data_in (otherwise zeros)
        logic is_read;    // capture readback lanes
        logic do_latch;   // pulse write_cfg
        logic legal;      // opcode is defined
    } sreg_dec_t;

    // Opcodes 6 and 7 fall through to an all-zero decode (illegal).
    function automatic sreg_dec_t sreg_decode(input sreg_cmd_t op);
        sreg_dec_t d;
        d = '0;
        case (op)
            CLEAR:       d.legal = 1'b1;
            WRITE:       begin d.legal = 1'b1; d.is_write = 1'b1; end
            READ:        begin d.legal = 1'b1; d.is_read  = 1'b1; end
            WRITE_READ:  begin d.legal = 1'b1; d.is_write = 1'b1; d.is_read = 1'b1; end
            LATCH:       begin d.legal = 1'b1; d.do_latch = 1'b1; end
            WRITE_LATCH: begin d.legal = 1'b1; d.is_write = 1'b1; d.do_latch = 1'b1; end
            default:     d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/sreg_xfer_ctrl_if.sv
// Command/response channel between the command FSM (master) and the
// shift-register controller (slave).
interface sreg_xfer_ctrl_if
    import sreg_pkg::*;
#(
    parameter int SREG_W = 42
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    sreg_cmd_t         cmd;
    logic [SREG_W-1:0] data_in;
    logic              abort;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_err;
    logic [SREG_W-1:0] data_out;

    modport master (
        output cmd_valid, cmd, data_in, abort, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_err, data_out
    );

    modport slave (
        input  cmd_valid, cmd, data_in, abort, rsp_ready,
        output cmd_ready, rsp_valid, rsp_err, data_out
    );
endinterface

// File: rtl/sreg_clk_div.sv
// Phase timer for sclk: phase_end strobes on the last clk of every
// CLK_DIV-long sclk half-period while enabled.
module sreg_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    output logic phase_end
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;

    assign phase_end = en && !clear && (cnt_q == LAST);

    // Count clks within the current phase; restart on clear, idle or phase end.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (rst) begin
            cnt_q <= '0;
        end else if (clear || !en || cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/sreg_xfer_ctrl.sv
// Serial shift-register controller for one IC configuration chain: shifts
// write data MSB first, captures N_RD_LANES readback taps, pulses the
// config latch and reports completion over a valid/ready response.
module sreg_xfer_ctrl
    import sreg_pkg::*;
#(
    parameter int SREG_W     = 42,
    parameter int N_RD_LANES = 2,
    parameter int CLK_DIV    = 2,
    parameter int CFG_PULSE  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    sreg_xfer_ctrl_if.slave       bus,
    input  logic [N_RD_LANES-1:0] sreg_in,
    output logic                  shift,
    output logic                  sclk,
    output logic                  serial_out,
    output logic                  write_cfg
);
    localparam int L     = SREG_W / N_RD_LANES;
    localparam int CNT_W = $clog2(SREG_W + 1);
    localparam int CFG_W = (CFG_PULSE > 1) ? $clog2(CFG_PULSE) : 1;
    localparam logic [CNT_W-1:0] N_FULL   = CNT_W'(SREG_W);
    localparam logic [CNT_W-1:0] N_LANE   = CNT_W'(L);
    localparam logic [CFG_W-1:0] CFG_LAST = CFG_W'(CFG_PULSE - 1);

    sreg_state_t       state_q, state_d;
    sreg_dec_t         dec_in;
    logic              wr_q, rd_q, latch_q, err_q, err_d;
    logic [CNT_W-1:0]  bit_cnt_q, n_bits;
    logic [CFG_W-1:0]  cfg_cnt_q;
    logic [SREG_W-1:0] tx_q, rx_q, rx_shifted;
    logic [L-1:0]      lane;
    logic              accept, abort_hit, phase_end, bit_step, last_bit, capture;
    logic              div_en, div_clear, shifting_d;
    logic              cmd_ready_q, rsp_valid_q, shift_q, sclk_q, serial_q, wcfg_q;

    assign dec_in     = sreg_decode(bus.cmd);
    assign accept     = (state_q == IDLE) && cmd_ready_q && bus.cmd_valid;
    assign abort_hit  = bus.abort && (state_q inside {SETUP, SCLK_LO, SCLK_HI, CFG});
    // READ only walks one lane length; everything else walks the full chain.
    assign n_bits     = (rd_q && !wr_q) ? N_LANE : N_FULL;
    assign last_bit   = (bit_cnt_q == n_bits - 1'b1);
    assign bit_step   = (state_q == SCLK_HI) && phase_end && !abort_hit;
    assign capture    = (state_q == SCLK_LO) && phase_end && !abort_hit && rd_q
                        && (bit_cnt_q < N_LANE);
    assign div_en     = (state_q inside {SCLK_LO, SCLK_HI});
    assign div_clear  = (state_q == SETUP) || abort_hit;
    assign shifting_d = (state_d inside {SETUP, SCLK_LO, SCLK_HI});

    sreg_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk       (clk),
        .rst       (rst),
        .en        (div_en),
        .clear     (div_clear),
        .phase_end (phase_end)
    );

    // Next-state logic; abort overrides any phase end in the same cycle.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latch).
        state_d = state_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!dec_in.legal) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end else if (dec_in.do_latch && !dec_in.is_write) begin
                        state_d = CFG;
                    end else begin
                        state_d = SETUP;
                    end
                end
            end
            SETUP:   state_d = SCLK_LO;
            SCLK_LO: if (phase_end) state_d = SCLK_HI;
            SCLK_HI: if (phase_end) state_d = last_bit ? HOLD : SCLK_LO;
            HOLD:    state_d = latch_q ? CFG : RESP;
            CFG:     if (cfg_cnt_q == CFG_LAST) state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_hit) begin
            state_d = RESP;
            err_d   = 1'b1;
        end
    end

    // Next readback value: each lane shifts left and takes its tap in the LSB.
    always_comb begin
        rx_shifted = rx_q;
        lane       = '0;
        for (int k = 0; k < N_RD_LANES; k++) begin
            lane                 = rx_q[k*L +: L];
            lane                 = lane << 1;
            lane[0]              = sreg_in[k];
            rx_shifted[k*L +: L] = lane;
        end
    end

    // State register, counters and pin/handshake outputs registered from state_d.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            latch_q     <= 1'b0;
            err_q       <= 1'b0;
            bit_cnt_q   <= '0;
            cfg_cnt_q   <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            shift_q     <= 1'b0;
            sclk_q      <= 1'b0;
            wcfg_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= (state_d == IDLE);
            rsp_valid_q <= (state_d == RESP);
            shift_q     <= shifting_d;
            sclk_q      <= (state_d == SCLK_HI);
            wcfg_q      <= (state_d == CFG);
            if (accept) begin
                wr_q    <= dec_in.is_write;
                rd_q    <= dec_in.is_read;
                latch_q <= dec_in.do_latch;
            end
            if (state_d == RESP && state_q != RESP) err_q <= err_d;
            if (accept)        bit_cnt_q <= '0;
            else if (bit_step) bit_cnt_q <= bit_cnt_q + 1'b1;
            cfg_cnt_q <= (state_q == CFG) ? cfg_cnt_q + 1'b1 : '0;
        end
    end

    // Transmit/receive shift registers and the serial data pin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q     <= '0;
            rx_q     <= '0;
            serial_q <= 1'b0;
        end else begin
            // tx_q holds the bits still to be sent after the one on serial_out.
            if (accept)        tx_q <= dec_in.is_write ? (bus.data_in << 1) : '0;
            else if (bit_step) tx_q <= tx_q << 1;

            if (!shifting_d)   serial_q <= 1'b0;
            else if (accept)   serial_q <= dec_in.is_write && bus.data_in[SREG_W-1];
            else if (bit_step) serial_q <= tx_q[SREG_W-1];

            if (state_q == SETUP && rd_q) rx_q <= '0;
            else if (capture)             rx_q <= rx_shifted;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = err_q;
    assign bus.data_out  = rx_q;
    assign shift         = shift_q;
    assign sclk          = sclk_q;
    assign serial_out    = serial_q;
    assign write_cfg     = wcfg_q;
endmodule

// File: tb/tb_sreg_xfer_ctrl.sv
// Directed bench for sreg_xfer_ctrl (8-bit chain, 2 lanes, CLK_DIV=1,
// CFG_PULSE=4). Drivers push expected responses; a monitor checks them.
module tb_sreg_xfer_ctrl;
    import sreg_pkg::*;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] sreg_in = '0;
    logic       shift, sclk, serial_out, write_cfg;

    sreg_xfer_ctrl_if #(.SREG_W(W)) bus ();

    sreg_xfer_ctrl #(
        .SREG_W(W), .N_RD_LANES(2), .CLK_DIV(1), .CFG_PULSE(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .sreg_in    (sreg_in),
        .shift      (shift),
        .sclk       (sclk),
        .serial_out (serial_out),
        .write_cfg  (write_cfg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         err;
        logic [W-1:0] data;
    } rsp_t;

    rsp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Response monitor: compares every accepted response against the queue head.
    initial begin : monitor
        rsp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.rsp_valid && bus.rsp_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp_queue_size", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                    check("data_out", 32'(bus.data_out), 32'(e.data));
                end
            end
        end
    end

    // Issue one command and measure pin activity until rsp_valid appears.
    task automatic do_cmd(input logic [2:0] op, input logic [7:0] din,
                          input logic [3:0] s0, input logic [3:0] s1,
                          input int abort_rise, input int exp_lat,
                          input int exp_rises, input int exp_wcfg,
                          input logic exp_err, input logic [7:0] exp_data);
        int       waited, rises, shift_cnt, wcfg_cnt, overlap;
        int       last_shift, first_wcfg, abort_cyc;
        logic     prev_sclk, got_rsp;
        logic [7:0] ser, exp_ser;
        rsp_t     r;

        waited = 0;
        @(negedge clk);
        while (!bus.cmd_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
        if (!bus.cmd_ready) return;

        sreg_in       = {s1[3], s0[3]};
        bus.cmd_valid = 1'b1;
        bus.cmd       = sreg_cmd_t'(op);
        bus.data_in   = din;
        r.err         = exp_err;
        r.data        = exp_data;
        sb.push_back(r);

        rises = 0; shift_cnt = 0; wcfg_cnt = 0; overlap = 0;
        last_shift = -1; first_wcfg = -1; abort_cyc = -1;
        prev_sclk = 1'b0; got_rsp = 1'b0; ser = '0;

        for (int cyc = 0; cyc < 200 && !got_rsp; cyc++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            if (abort_cyc >= 0 && cyc == abort_cyc + 1) begin
                check("abort_sclk", 32'(sclk), 32'd0);
                check("abort_shift", 32'(shift), 32'd0);
                bus.abort = 1'b0;
            end
            if (shift) begin
                shift_cnt++;
                last_shift = cyc;
            end
            if (write_cfg) begin
                wcfg_cnt++;
                if (first_wcfg < 0) first_wcfg = cyc;
                if (sclk) overlap++;
            end
            if (sclk && !prev_sclk) begin
                ser = {ser[6:0], serial_out};
                rises++;
                if (rises < 4) sreg_in = {s1[3-rises], s0[3-rises]};
                else           sreg_in = '0;
                if (rises == abort_rise) begin
                    bus.abort = 1'b1;
                    abort_cyc = cyc;
                end
            end
            prev_sclk = sclk;
            if (bus.rsp_valid) begin
                got_rsp = 1'b1;
                check("latency", 32'(cyc), 32'(exp_lat));
            end
        end

        check("rsp_seen", 32'(got_rsp), 32'd1);
        check("sclk_rises", 32'(rises), 32'(exp_rises));
        exp_ser = (op == 3'd1 || op == 3'd3 || op == 3'd5) ? din >> (8 - exp_rises) : 8'h00;
        check("serial_bits", 32'(ser), 32'(exp_ser));
        check("shift_cycles", 32'(shift_cnt), (exp_rises == 0) ? 32'd0 : 32'(1 + 2 * exp_rises));
        check("write_cfg_cycles", 32'(wcfg_cnt), 32'(exp_wcfg));
        check("sclk_during_cfg", 32'(overlap), 32'd0);
        if (exp_wcfg > 0 && exp_rises > 0)
            check("cfg_after_shift", 32'(first_wcfg), 32'(last_shift + 2));
        bus.abort = 1'b0;
        sreg_in   = '0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int   waited;
        logic seen_hi;

        bus.cmd_valid = 1'b0;
        bus.cmd       = CLEAR;
        bus.data_in   = '0;
        bus.abort     = 1'b0;
        bus.rsp_ready = 1'b1;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_data_out", 32'(bus.data_out), 32'd0);
        check("rst_pins", 32'({shift, sclk, serial_out, write_cfg}), 32'd0);
        rst = 1'b0;
        #1 check("cmd_ready_after_release", 32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        check("cmd_ready_one_clk_later", 32'(bus.cmd_ready), 32'd1);

        //        op    din    s0       s1       abort lat rises wcfg err data
        do_cmd(3'd1, 8'hA5, 4'b0000, 4'b0000, 0,   18, 8,    0,   0,  8'h00); // WRITE
        do_cmd(3'd2, 8'hFF, 4'b1011, 4'b0110, 0,   10, 4,    0,   0,  8'h6B); // READ
        do_cmd(3'd5, 8'h5A, 4'b0000, 4'b0000, 0,   22, 8,    4,   0,  8'h6B); // WRITE_LATCH
        do_cmd(3'd6, 8'hFF, 4'b1111, 4'b1111, 0,   0,  0,    0,   1,  8'h6B); // illegal
        do_cmd(3'd1, 8'hFF, 4'b0000, 4'b0000, 3,   7,  3,    0,   1,  8'h6B); // WRITE + abort
        do_cmd(3'd3, 8'h3C, 4'b1100, 4'b1001, 0,   18, 8,    0,   0,  8'h9C); // WRITE_READ
        do_cmd(3'd0, 8'hFF, 4'b1111, 4'b1111, 0,   18, 8,    0,   0,  8'h9C); // CLEAR
        do_cmd(3'd4, 8'hFF, 4'b0000, 4'b0000, 0,   4,  0,    4,   0,  8'h9C); // LATCH
        do_cmd(3'd7, 8'h00, 4'b0000, 4'b0000, 0,   0,  0,    0,   1,  8'h9C); // illegal

        // Asynchronous reset in the middle of an sclk-high phase.
        waited = 0;
        @(negedge clk);
        while (!bus.cmd_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd       = WRITE;
        bus.data_in   = 8'hC3;
        seen_hi       = 1'b0;
        for (int i = 0; i < 20 && !seen_hi; i++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            seen_hi = sclk;
        end
        check("sclk_high_before_rst", 32'(seen_hi), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_sclk", 32'(sclk), 32'd0);
        check("async_rst_shift", 32'(shift), 32'd0);
        check("async_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("async_rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("async_rst_data_out", 32'(bus.data_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("cmd_ready_at_release", 32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        check("cmd_ready_after_rst", 32'(bus.cmd_ready), 32'd1);

        do_cmd(3'd1, 8'h81, 4'b0000, 4'b0000, 0, 18, 8, 0, 0, 8'h00); // WRITE after reset

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
